// File: rtl/const_load_seq.sv
// Constant-load sequencer: writes a 32-bit constant into the register file as an
// upper-half write followed by an optional full-value write, sharing the port with the core.
module const_load_seq #(
  parameter int MAX_STALL = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_value,
  input  logic        core_we,
  input  logic [4:0]  core_wa,
  input  logic [31:0] core_wd,
  output logic        core_stall,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, UPPER, LOWER} state_t;

  localparam logic [3:0] STALL_MAX = 4'(MAX_STALL);

  state_t      state_q, state_d;
  logic [3:0]  stall_q, stall_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] val_q, val_d;
  logic        active, own, lower_zero;

  assign active     = (state_q != IDLE);
  assign lower_zero = (val_q[15:0] == 16'h0000);
  // A reset cycle never lets the sequencer take the port, so an abort writes nothing.
  assign own        = active && !reset && (!core_we || (stall_q == STALL_MAX));

  assign req_ready  = !active;
  assign busy       = active;
  assign core_stall = own && core_we;
  assign done       = own && ((state_q == LOWER) || lower_zero);

  always_comb begin
    rf_we = core_we;
    rf_wa = core_wa;
    rf_wd = core_wd;
    if (own) begin
      rf_we = (rd_q != 5'd0);
      rf_wa = rd_q;
      rf_wd = (state_q == UPPER) ? {val_q[31:16], 16'h0000} : val_q;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    rd_d    = rd_q;
    val_d   = val_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = UPPER;
        stall_d = 4'd0;
        rd_d    = req_rd;
        val_d   = req_value;
      end
      UPPER, LOWER: begin
        if (own) begin
          stall_d = 4'd0;
          state_d = (state_q == UPPER && !lower_zero) ? LOWER : IDLE;
        end else begin
          stall_d = stall_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stall_q <= 4'd0;
      rd_q    <= 5'd0;
      val_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
    end
  end

endmodule

// File: tb/tb_const_load_seq.sv
// Bench for const_load_seq: a pending-write queue model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_const_load_seq;
  localparam int MAX_STALL = 8;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, core_we, core_stall, rf_we, busy, done;
  logic [4:0]  req_rd, core_wa, rf_wa;
  logic [31:0] req_value, core_wd, rf_wd;

  int total = 0, passed = 0;
  bit chk_en = 1'b0;

  const_load_seq #(.MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_value(req_value), .core_we(core_we), .core_wa(core_wa),
    .core_wd(core_wd), .core_stall(core_stall), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  // Model: a queue of register writes still owed, plus how long the core has held the port.
  logic [4:0]  m_wa[$];
  logic [31:0] m_wd[$];
  int          m_wait = 0;

  always @(negedge clk) if (chk_en) begin
    bit m_busy, m_own;
    m_busy = (m_wa.size() != 0);
    m_own  = m_busy && !reset && (!core_we || m_wait == MAX_STALL);
    chk("m_ready", 32'(req_ready), 32'(!m_busy));
    chk("m_busy",  32'(busy),      32'(m_busy));
    chk("m_stall", 32'(core_stall), 32'(m_own && core_we));
    chk("m_done",  32'(done),      32'(m_own && m_wa.size() == 1));
    if (m_own) begin
      chk("m_we", 32'(rf_we), 32'(m_wa[0] != 5'd0));
      chk("m_wa", 32'(rf_wa), 32'(m_wa[0]));
      chk("m_wd", rf_wd, m_wd[0]);
    end else begin
      chk("m_we", 32'(rf_we), 32'(core_we));
      chk("m_wa", 32'(rf_wa), 32'(core_wa));
      chk("m_wd", rf_wd, core_wd);
    end
    if (reset) begin
      m_wa.delete(); m_wd.delete(); m_wait = 0;
    end else if (m_own) begin
      void'(m_wa.pop_front()); void'(m_wd.pop_front()); m_wait = 0;
    end else if (m_busy && core_we) begin
      m_wait++;
    end else if (!m_busy && req_valid) begin
      m_wa.push_back(req_rd); m_wd.push_back({req_value[31:16], 16'h0000});
      if (req_value[15:0] != 16'h0000) begin
        m_wa.push_back(req_rd); m_wd.push_back(req_value);
      end
      m_wait = 0;
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_rd = '0; req_value = '0;
    core_we = 1'b0; core_wa = '0; core_wd = '0;
    cyc(); chk_en = 1'b1;
    cyc(); reset = 1'b0;
    look(); chk("rst ready", 32'(req_ready), 1); chk("rst busy", 32'(busy), 0);

    // Two-write load
    cyc(); req_valid = 1'b1; req_rd = 5'd5; req_value = 32'h1234_5678;
    look(); chk("t1 ready", 32'(req_ready), 1);
    cyc(); req_valid = 1'b0;
    look(); chk("t1 we0", 32'(rf_we), 1); chk("t1 wa0", 32'(rf_wa), 5);
    chk("t1 wd0", rf_wd, 32'h1234_0000); chk("t1 done0", 32'(done), 0);
    cyc(); look(); chk("t1 wd1", rf_wd, 32'h1234_5678); chk("t1 done1", 32'(done), 1);
    cyc(); look(); chk("t1 ready2", 32'(req_ready), 1);

    // Lower half zero: single write
    req_valid = 1'b1; req_rd = 5'd7; req_value = 32'hABCD_0000;
    cyc(); req_valid = 1'b0;
    look(); chk("t2 wd", rf_wd, 32'hABCD_0000); chk("t2 wa", 32'(rf_wa), 7);
    chk("t2 done", 32'(done), 1);
    cyc(); look(); chk("t2 ready", 32'(req_ready), 1); chk("t2 we", 32'(rf_we), 0);

    // Core holds the port continuously
    req_valid = 1'b1; req_rd = 5'd3; req_value = 32'h55AA_1234;
    core_we = 1'b1; core_wa = 5'd12; core_wd = 32'hC000_00FF;
    for (int i = 0; i < 8; i++) begin
      cyc(); req_valid = 1'b0; core_wd = 32'hC000_0000 + 32'(i);
      look(); chk("t3 up pass", rf_wd, 32'hC000_0000 + 32'(i));
      chk("t3 up nostall", 32'(core_stall), 0);
    end
    cyc(); look(); chk("t3 up stall", 32'(core_stall), 1);
    chk("t3 up wd", rf_wd, 32'h55AA_0000); chk("t3 up wa", 32'(rf_wa), 3);
    for (int i = 0; i < 8; i++) begin
      cyc(); core_wd = 32'hD000_0000 + 32'(i);
      look(); chk("t3 lo pass", rf_wd, 32'hD000_0000 + 32'(i));
    end
    cyc(); look(); chk("t3 lo stall", 32'(core_stall), 1);
    chk("t3 lo wd", rf_wd, 32'h55AA_1234); chk("t3 lo done", 32'(done), 1);
    cyc(); core_we = 1'b0;
    look(); chk("t3 stall end", 32'(core_stall), 0);

    // Register zero is never written
    req_valid = 1'b1; req_rd = 5'd0; req_value = 32'hFFFF_FFFF;
    cyc(); req_valid = 1'b0;
    look(); chk("t4 we0", 32'(rf_we), 0); chk("t4 done0", 32'(done), 0);
    cyc(); look(); chk("t4 we1", 32'(rf_we), 0); chk("t4 done1", 32'(done), 1);

    // Reset while in LOWER
    cyc(); req_valid = 1'b1; req_rd = 5'd9; req_value = 32'h1111_2222;
    cyc(); req_valid = 1'b0;
    look(); chk("t5 upper wd", rf_wd, 32'h1111_0000);
    cyc(); reset = 1'b1;
    look(); chk("t5 rst we", 32'(rf_we), 0); chk("t5 rst done", 32'(done), 0);
    cyc(); reset = 1'b0;
    look(); chk("t5 ready", 32'(req_ready), 1); chk("t5 busy", 32'(busy), 0);
    chk("t5 we", 32'(rf_we), 0); chk("t5 done", 32'(done), 0);

    // Back-to-back with req_valid held
    cyc(); req_valid = 1'b1; req_rd = 5'd4; req_value = 32'h0001_0002;
    cyc(); req_rd = 5'd6; req_value = 32'h7777_0000;
    look(); chk("t6 upper wd", rf_wd, 32'h0001_0000); chk("t6 ready0", 32'(req_ready), 0);
    cyc(); look(); chk("t6 lower wd", rf_wd, 32'h0001_0002); chk("t6 done", 32'(done), 1);
    chk("t6 ready1", 32'(req_ready), 0);
    cyc(); look(); chk("t6 ready2", 32'(req_ready), 1); chk("t6 idle we", 32'(rf_we), 0);
    cyc(); req_valid = 1'b0;
    look(); chk("t6 second wd", rf_wd, 32'h7777_0000); chk("t6 second wa", 32'(rf_wa), 6);
    chk("t6 second done", 32'(done), 1);
    cyc(); cyc(); look();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
